// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the fetch (IF) and
// memory (DM) stages. One transaction outstanding at a time.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   if_req_*  / if_rsp_*         fetch read request (valid/ready) and response (valid)
//   dm_req_*  / dm_rsp_*         data load/store request (valid/ready) and response
//   mem_req_* / mem_rsp_*        memory-side request (valid/ready) and response
//   bus_err                      1-cycle pulse when a response times out
//
// Arbitration: DM has priority; after STARVE_MAX consecutive DM grants while IF
// waits, IF is forced through. Handshake outputs are combinational because the
// accept (req_ready) and the response pass-through must land in the same cycle.
//
// Optional feature macro: MEM_ARB_TIMEOUT_EN -- aborts a transaction after
// TIMEOUT cycles without a response (rsp_valid with zero data, bus_err pulse).
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_valid,
  input  logic [ADDR_W-1:0]   if_req_addr,
  output logic                if_req_ready,
  output logic                if_rsp_valid,
  output logic [DATA_W-1:0]   if_rsp_rdata,
  input  logic                dm_req_valid,
  input  logic                dm_req_we,
  input  logic [DATA_W/8-1:0] dm_req_be,
  input  logic [ADDR_W-1:0]   dm_req_addr,
  input  logic [DATA_W-1:0]   dm_req_wdata,
  output logic                dm_req_ready,
  output logic                dm_rsp_valid,
  output logic [DATA_W-1:0]   dm_rsp_rdata,
  output logic                mem_req_valid,
  output logic                mem_req_we,
  output logic [DATA_W/8-1:0] mem_req_be,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic [DATA_W-1:0]   mem_req_wdata,
  input  logic                mem_req_ready,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rsp_rdata,
  output logic                bus_err
);

  localparam int unsigned BE_W = DATA_W / 8;
  localparam int unsigned SC_W = 4;
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_WAIT} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM} owner_t;

  state_t          state;
  owner_t          owner;
  owner_t          sel;
  logic [SC_W-1:0] starve_cnt;
  logic            accept;
  logic            wait_act;
  logic            rsp_fire;
  logic            tmo_fire;
  logic            done;

  // Requester driving the memory this cycle: fresh arbitration in IDLE, latched owner in HOLD
  always_comb begin
    sel = OWN_NONE;
    if (!rst) begin
      if (state == ST_IDLE) begin
        if (if_req_valid && (!dm_req_valid || starve_cnt == SC_W'(STARVE_MAX)))
          sel = OWN_IF;
        else if (dm_req_valid)
          sel = OWN_DM;
      end else if (state == ST_HOLD) begin
        sel = owner;
      end
    end
  end

  // Memory request mux; IF is always a full-word read
  always_comb begin
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    mem_req_be    = '0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    if (sel == OWN_IF) begin
      mem_req_valid = 1'b1;
      mem_req_addr  = if_req_addr;
    end else if (sel == OWN_DM) begin
      mem_req_valid = 1'b1;
      mem_req_we    = dm_req_we;
      mem_req_be    = BE_W'(dm_req_be);
      mem_req_addr  = dm_req_addr;
      mem_req_wdata = dm_req_wdata;
    end
  end

  assign accept       = mem_req_valid && mem_req_ready;
  assign if_req_ready = accept && (sel == OWN_IF);
  assign dm_req_ready = accept && (sel == OWN_DM);

  assign wait_act = !rst && (state == ST_WAIT);
  assign rsp_fire = wait_act && mem_rsp_valid;

`ifdef MEM_ARB_TIMEOUT_EN
  logic [TO_W-1:0] tmo_cnt;

  // Counts cycles spent in WAIT_RSP; zero on every entry
  always_ff @(posedge clk) begin
    if (rst || state != ST_WAIT) tmo_cnt <= '0;
    else                         tmo_cnt <= tmo_cnt + TO_W'(1);
  end

  assign tmo_fire = wait_act && !mem_rsp_valid && (tmo_cnt == TO_W'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^TO_W'(TIMEOUT);
  assign tmo_fire       = 1'b0;
`endif

  assign done    = rsp_fire || tmo_fire;
  assign bus_err = tmo_fire;

  // Responses go only to the owner; a timed-out response carries zero data
  assign if_rsp_valid = done && (owner == OWN_IF);
  assign dm_rsp_valid = done && (owner == OWN_DM);
  assign if_rsp_rdata = (if_rsp_valid && rsp_fire) ? mem_rsp_rdata : '0;
  assign dm_rsp_rdata = (dm_rsp_valid && rsp_fire) ? mem_rsp_rdata : '0;

  // Transaction FSM and starvation counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      owner      <= OWN_NONE;
      starve_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (sel != OWN_NONE) begin
            owner <= sel;
            state <= mem_req_ready ? ST_WAIT : ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (mem_req_ready) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (done) begin
            state <= ST_IDLE;
            owner <= OWN_NONE;
          end
        end
        default: begin
          state <= ST_IDLE;
          owner <= OWN_NONE;
        end
      endcase

      if (if_req_ready)
        starve_cnt <= '0;
      else if (dm_req_ready && if_req_valid) begin
        if (starve_cnt != SC_W'(STARVE_MAX)) starve_cnt <= starve_cnt + SC_W'(1);
      end else if (state == ST_IDLE && !if_req_valid)
        starve_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned BE_W       = DATA_W / 8;
  localparam int unsigned STARVE_MAX = 4;
  localparam int unsigned TIMEOUT    = 8;
  localparam int SEL_NONE = 0;
  localparam int SEL_IF   = 1;
  localparam int SEL_DM   = 2;

  logic              clk;
  logic              rst;
  logic              if_req_valid;
  logic [ADDR_W-1:0] if_req_addr;
  logic              if_req_ready;
  logic              if_rsp_valid;
  logic [DATA_W-1:0] if_rsp_rdata;
  logic              dm_req_valid;
  logic              dm_req_we;
  logic [BE_W-1:0]   dm_req_be;
  logic [ADDR_W-1:0] dm_req_addr;
  logic [DATA_W-1:0] dm_req_wdata;
  logic              dm_req_ready;
  logic              dm_rsp_valid;
  logic [DATA_W-1:0] dm_rsp_rdata;
  logic              mem_req_valid;
  logic              mem_req_we;
  logic [BE_W-1:0]   mem_req_be;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_wdata;
  logic              mem_req_ready;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rsp_rdata;
  logic              bus_err;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_rsp_valid(if_rsp_valid), .if_rsp_rdata(if_rsp_rdata),
    .dm_req_valid(dm_req_valid), .dm_req_we(dm_req_we), .dm_req_be(dm_req_be),
    .dm_req_addr(dm_req_addr), .dm_req_wdata(dm_req_wdata), .dm_req_ready(dm_req_ready),
    .dm_rsp_valid(dm_rsp_valid), .dm_rsp_rdata(dm_rsp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we), .mem_req_be(mem_req_be),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: what the arbiter is doing at transaction level
  bit m_busy = 0;    // a transaction has been accepted and awaits its response
  bit m_hold = 0;    // a request is presented but not yet accepted
  int m_own  = SEL_NONE;
  int m_starve = 0;
  int m_wait = 0;    // cycles already spent waiting for the response
  bit m_dm_we = 0;
  bit if_fire = 0;
  bit dm_fire = 0;
  bit rec_grants = 0;
  int grants[$];

  int e_sel;
  bit e_acc, e_tmo, e_done, e_if_rsp, e_dm_rsp, was_idle, active;

  initial forever begin
    @(negedge clk);
    if (rst || m_busy)        e_sel = SEL_NONE;
    else if (m_hold)          e_sel = m_own;
    else if (if_req_valid && (!dm_req_valid || m_starve == STARVE_MAX)) e_sel = SEL_IF;
    else if (dm_req_valid)    e_sel = SEL_DM;
    else                      e_sel = SEL_NONE;
    e_acc = (e_sel != SEL_NONE) && mem_req_ready;
    e_tmo = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    e_tmo = !rst && m_busy && !mem_rsp_valid && (m_wait == TIMEOUT - 1);
`endif
    e_done   = !rst && m_busy && (mem_rsp_valid || e_tmo);
    e_if_rsp = e_done && m_own == SEL_IF;
    e_dm_rsp = e_done && m_own == SEL_DM;
    active   = m_busy || m_hold;

    check_eq("mem_req_valid", mem_req_valid, e_sel != SEL_NONE);
    if (e_sel == SEL_IF) begin
      check_eq("if_mem_addr", mem_req_addr, if_req_addr);
      check_eq("if_mem_we", mem_req_we, 0);
      check_eq("if_mem_be", mem_req_be, 0);
    end else if (e_sel == SEL_DM) begin
      check_eq("dm_mem_addr", mem_req_addr, dm_req_addr);
      check_eq("dm_mem_we", mem_req_we, dm_req_we);
      check_eq("dm_mem_be", mem_req_be, dm_req_be);
      check_eq("dm_mem_wdata", mem_req_wdata, dm_req_wdata);
    end
    check_eq("if_req_ready", if_req_ready, e_acc && e_sel == SEL_IF);
    check_eq("dm_req_ready", dm_req_ready, e_acc && e_sel == SEL_DM);
    check_eq("if_rsp_valid", if_rsp_valid, e_if_rsp);
    check_eq("dm_rsp_valid", dm_rsp_valid, e_dm_rsp);
    check_eq("bus_err", bus_err, e_tmo);
    if (e_if_rsp)
      check_eq("if_rsp_rdata", if_rsp_rdata, e_tmo ? 0 : mem_rsp_rdata);
    else if (!active || m_own != SEL_IF)
      check_eq("if_rdata_idle", if_rsp_rdata, 0);
    if (e_dm_rsp && !m_dm_we)
      check_eq("dm_rsp_rdata", dm_rsp_rdata, e_tmo ? 0 : mem_rsp_rdata);
    else if (!active || m_own != SEL_DM)
      check_eq("dm_rdata_idle", dm_rsp_rdata, 0);

    if (rec_grants && if_req_ready) grants.push_back(SEL_IF);
    if (rec_grants && dm_req_ready) grants.push_back(SEL_DM);
    if_fire = if_req_ready;
    dm_fire = dm_req_ready;

    // Advance model to the state after the coming clock edge
    if (rst) begin
      m_busy = 0; m_hold = 0; m_own = SEL_NONE; m_starve = 0; m_wait = 0;
    end else begin
      was_idle = !m_busy && !m_hold;
      if (e_done) m_busy = 0;
      else if (m_busy) m_wait++;
      if (e_acc) begin
        m_busy = 1; m_hold = 0; m_own = e_sel; m_wait = 0; m_dm_we = dm_req_we;
      end else if (e_sel != SEL_NONE) begin
        m_hold = 1; m_own = e_sel;
      end
      if (e_acc && e_sel == SEL_IF) m_starve = 0;
      else if (e_acc && e_sel == SEL_DM && if_req_valid)
        m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
      else if (was_idle && !if_req_valid) m_starve = 0;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req_valid = 0; if_req_addr = '0;
    dm_req_valid = 0; dm_req_we = 0; dm_req_be = '0; dm_req_addr = '0; dm_req_wdata = '0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_rdata = '0;
  endtask

  task automatic do_reset();
    rst = 1; idle_inputs();
    cyc(); cyc();
    rst = 0;
  endtask

  initial begin
    // Reset with both requesters asserting valid
    rst = 1; idle_inputs();
    if_req_valid = 1; if_req_addr = 32'h40;
    dm_req_valid = 1; dm_req_addr = 32'h80; mem_req_ready = 1;
    #1;
    check_eq("rst_mem_req_valid", mem_req_valid, 0);
    check_eq("rst_if_ready", if_req_ready, 0);
    check_eq("rst_dm_ready", dm_req_ready, 0);
    cyc(); cyc(); cyc();
    rst = 0; idle_inputs();
    cyc();

    // IF-only read
    if_req_valid = 1; if_req_addr = 32'h4; mem_req_ready = 1;
    #1 check_eq("if_read_ready", if_req_ready, 1);
    cyc();
    if_req_valid = 0; mem_rsp_valid = 1; mem_rsp_rdata = 32'h00500113;
    #1;
    check_eq("if_read_rsp_valid", if_rsp_valid, 1);
    check_eq("if_read_rdata", if_rsp_rdata, 32'h00500113);
    check_eq("if_read_dm_rsp", dm_rsp_valid, 0);
    cyc();
    idle_inputs();
    cyc();

    // Starvation: both valid continuously, memory always ready and responding
    do_reset();
    grants.delete();
    rec_grants = 1;
    if_req_valid = 1; if_req_addr = 32'h1000;
    dm_req_valid = 1; dm_req_addr = 32'h2000; dm_req_we = 0;
    mem_req_ready = 1; mem_rsp_valid = 1; mem_rsp_rdata = 32'h1234_5678;
    repeat (20) cyc();
    rec_grants = 0;
    check_eq("starve_grant_count", grants.size(), 10);
    foreach (grants[i])
      check_eq("starve_grant_order", grants[i], (i % 5 == 4) ? SEL_IF : SEL_DM);
    idle_inputs();
    cyc(); cyc();

    // DM store held while memory stalls; IF request arrives meanwhile
    do_reset();
    dm_req_valid = 1; dm_req_we = 1; dm_req_be = 4'h3;
    dm_req_addr = 32'h100; dm_req_wdata = 32'hCAFE_F00D;
    cyc();
    if_req_valid = 1; if_req_addr = 32'h200;
    #1 check_eq("hold_dm_ready_low", dm_req_ready, 0);
    cyc(); cyc();
    mem_req_ready = 1;
    #1;
    check_eq("hold_dm_ready", dm_req_ready, 1);
    check_eq("hold_mem_addr", mem_req_addr, 32'h100);
    check_eq("hold_mem_be", mem_req_be, 4'h3);
    cyc();
    dm_req_valid = 0; mem_rsp_valid = 1; mem_rsp_rdata = 32'hDEAD_BEEF;
    #1 check_eq("hold_dm_ack", dm_rsp_valid, 1);
    cyc();
    mem_rsp_valid = 0;
    #1 check_eq("hold_if_next", if_req_ready, 1);
    cyc();
    if_req_valid = 0; mem_rsp_valid = 1;
    cyc();
    idle_inputs();
    cyc();

    // Reset while waiting for a response; late response must be ignored
    do_reset();
    if_req_valid = 1; if_req_addr = 32'h8; mem_req_ready = 1;
    cyc();
    if_req_valid = 0; rst = 1;
    cyc();
    rst = 0;
    cyc();
    mem_rsp_valid = 1; mem_rsp_rdata = 32'hAAAA_5555;
    #1;
    check_eq("late_rsp_if", if_rsp_valid, 0);
    check_eq("late_rsp_dm", dm_rsp_valid, 0);
    cyc();
    idle_inputs();
    cyc();

`ifdef MEM_ARB_TIMEOUT_EN
    // Response timeout
    do_reset();
    if_req_valid = 1; if_req_addr = 32'hC; mem_req_ready = 1;
    cyc();
    if_req_valid = 0;
    for (int i = 1; i < TIMEOUT; i++) begin
      #1 check_eq("tmo_early", bus_err, 0);
      cyc();
    end
    #1;
    check_eq("tmo_rsp_valid", if_rsp_valid, 1);
    check_eq("tmo_rdata", if_rsp_rdata, 0);
    check_eq("tmo_bus_err", bus_err, 1);
    cyc();
    if_req_valid = 1; if_req_addr = 32'h10;
    #1 check_eq("tmo_next_accept", if_req_ready, 1);
    cyc();
    if_req_valid = 0; mem_rsp_valid = 1; mem_rsp_rdata = 32'h0BAD_F00D;
    #1 check_eq("tmo_next_rsp", if_rsp_valid, 1);
    cyc();
    idle_inputs();
    cyc();
`endif

    // Randomized traffic; requesters hold valid and fields until accepted
    do_reset();
    repeat (3000) begin
      if (!if_req_valid || if_fire) begin
        if_req_valid = 1'($urandom_range(0, 1));
        if_req_addr  = $urandom & 32'hFFFF_FFFC;
      end
      if (!dm_req_valid || dm_fire) begin
        dm_req_valid = 1'($urandom_range(0, 1));
        dm_req_we    = 1'($urandom_range(0, 1));
        dm_req_be    = 4'($urandom_range(0, 15));
        dm_req_addr  = $urandom & 32'hFFFF_FFFC;
        dm_req_wdata = $urandom;
      end
      mem_req_ready = ($urandom_range(0, 2) != 0);
      mem_rsp_valid = ($urandom_range(0, 2) == 0);
      mem_rsp_rdata = $urandom;
      rst = ($urandom_range(0, 63) == 0);
      cyc();
    end
    rst = 0; idle_inputs();
    cyc(); cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
